// File: rtl/mem_lsu_if.sv
// Request/response handshake and word-memory bus between a core and the load/store unit.
// slave = LSU side, master = core plus memory side.
interface mem_lsu_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_misaligned;
   logic [31:0] mem_address;
   logic [31:0] mem_data_out;
   logic [31:0] mem_data_in;
   logic        mem_we;

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
             rsp_ready, mem_data_in,
      output req_ready, rsp_valid, rsp_rdata, rsp_misaligned,
             mem_address, mem_data_out, mem_we
   );

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
             rsp_ready, mem_data_in,
      input  req_ready, rsp_valid, rsp_rdata, rsp_misaligned,
             mem_address, mem_data_out, mem_we
   );
endinterface

// File: rtl/mem_lsu.sv
// Load/store unit: byte/half/word accesses onto a word-wide memory, with alignment
// faults and read-modify-write for sub-word stores.
module mem_lsu (
   input logic      clk,
   input logic      resetn,
   mem_lsu_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

   state_t      r_state;
   logic        r_we;
   logic [1:0]  r_size;
   logic        r_unsigned;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_merge;
   logic [31:0] r_rdata;
   logic        r_mis;

   logic        w_mis;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load;
   logic [31:0] w_merge;
   logic        w_mem_we;

   always_comb begin
      unique case (bus.req_size)
         2'b00:   w_mis = 1'b0;
         2'b01:   w_mis = bus.req_addr[0];
         2'b10:   w_mis = |bus.req_addr[1:0];
         default: w_mis = 1'b1;
      endcase
   end

   always_comb begin
      w_byte = bus.mem_data_in[{r_addr[1:0], 3'b000} +: 8];
      w_half = bus.mem_data_in[{r_addr[1], 4'b0000} +: 16];
      unique case (r_size)
         2'b00:   w_load = r_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
         2'b01:   w_load = r_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
         default: w_load = bus.mem_data_in;
      endcase
      w_merge = bus.mem_data_in;
      if (r_size == 2'b00)
         w_merge[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
      else
         w_merge[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
   end

   // Reset gates the write strobe combinationally so an interrupted store never lands.
   assign w_mem_we = resetn &&
                     (((r_state == ACCESS) && r_we && (r_size == 2'b10)) || (r_state == WRITE));

   assign bus.req_ready      = (r_state == IDLE);
   assign bus.rsp_valid      = (r_state == RESP);
   assign bus.rsp_rdata      = r_rdata;
   assign bus.rsp_misaligned = r_mis;
   assign bus.mem_we         = w_mem_we;
   assign bus.mem_address    = ((r_state == ACCESS) || (r_state == WRITE)) ?
                               {r_addr[31:2], 2'b00} : '0;
   assign bus.mem_data_out   = !w_mem_we ? '0 : ((r_state == WRITE) ? r_merge : r_wdata);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state    <= IDLE;
         r_we       <= 1'b0;
         r_size     <= '0;
         r_unsigned <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_merge    <= '0;
         r_rdata    <= '0;
         r_mis      <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: if (bus.req_valid) begin
               r_we       <= bus.req_we;
               r_size     <= bus.req_size;
               r_unsigned <= bus.req_unsigned;
               r_addr     <= bus.req_addr;
               r_wdata    <= bus.req_wdata;
               r_rdata    <= '0;
               r_mis      <= w_mis;
               r_state    <= w_mis ? RESP : ACCESS;
            end
            ACCESS: begin
               if (!r_we) begin
                  r_rdata <= w_load;
                  r_state <= RESP;
               end else if (r_size == 2'b10) begin
                  r_state <= RESP;
               end else begin
                  r_merge <= w_merge;
                  r_state <= WRITE;
               end
            end
            WRITE: r_state <= RESP;
            RESP:  if (bus.rsp_ready) r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_lsu.sv
// Directed and random checks of mem_lsu against a byte-addressed reference memory.
module tb_mem_lsu;
   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   we_cnt = 0;

   bit [31:0] mem   [256];
   bit [7:0]  ref_b [1024];

   mem_lsu_if bus ();

   mem_lsu u_dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus.slave)
   );

   always #5 clk = ~clk;

   assign bus.mem_data_in = mem[bus.mem_address[9:2]];

   always @(posedge clk) begin
      if (bus.mem_we === 1'b1) begin
         mem[bus.mem_address[9:2]] <= bus.mem_data_out;
         we_cnt <= we_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic bit [31:0] ref_word(input int unsigned a);
      int unsigned w;
      w = a & 32'h3FC;
      return {ref_b[w+3], ref_b[w+2], ref_b[w+1], ref_b[w]};
   endfunction

   // One full request: drive, measure latency, hold response, release, check memory.
   task automatic do_req(input bit we, input bit [1:0] size, input bit uns,
                         input bit [31:0] addr, input bit [31:0] wdata, input int hold);
      int unsigned n;
      int          lat;
      int          w0;
      bit          mis;
      bit [31:0]   exp_rd;
      bit [31:0]   sign;
      int          exp_lat;
      logic [31:0] held;
      n    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      mis  = (size == 2'd3) || (addr % n != 0);
      exp_rd = 32'h0;
      if (!mis && !we) begin
         for (int unsigned i = 0; i < n; i++) exp_rd |= 32'(ref_b[addr+i]) << (8*i);
         if (!uns && n < 4) begin
            sign = 32'h1 << (8*n - 1);
            if ((exp_rd & sign) != 0) exp_rd = exp_rd - (sign << 1);
         end
      end
      exp_lat = mis ? 1 : (we && n < 4) ? 3 : 2;

      chk("req_ready_idle", bus.req_ready, 1'b1);
      bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = size;
      bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wdata;
      bus.rsp_ready = 1'b0;
      w0 = we_cnt;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      bus.req_wdata = $urandom;
      lat = 1;
      while (bus.rsp_valid !== 1'b1 && lat < 8) begin
         chk("req_ready_busy", bus.req_ready, 1'b0);
         @(posedge clk); #1; lat++;
      end
      chk("latency", lat, exp_lat);
      chk("rsp_rdata", bus.rsp_rdata, exp_rd);
      chk("rsp_misaligned", bus.rsp_misaligned, mis);
      chk("req_ready_resp", bus.req_ready, 1'b0);
      held = bus.rsp_rdata;
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         chk("hold_valid", bus.rsp_valid, 1'b1);
         chk("hold_rdata", bus.rsp_rdata, held);
         chk("hold_ready", bus.req_ready, 1'b0);
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
      chk("rsp_done", bus.rsp_valid, 1'b0);
      chk("back_idle", bus.req_ready, 1'b1);

      if (!mis && we)
         for (int unsigned i = 0; i < n; i++) ref_b[addr+i] = wdata[8*i +: 8];
      chk("mem_we_count", we_cnt - w0, (!mis && we) ? 1 : 0);
      chk("mem_word", mem[addr[9:2]], ref_word(addr));
   endtask

   initial begin
      bit [31:0] a;
      bus.req_valid = 0; bus.req_we = 0; bus.req_size = 0; bus.req_unsigned = 0;
      bus.req_addr = 0; bus.req_wdata = 0; bus.rsp_ready = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready", bus.req_ready, 1'b1);
      chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
      chk("rst_mem_address", bus.mem_address, 32'h0);
      chk("rst_mem_data_out", bus.mem_data_out, 32'h0);
      chk("rst_mem_we", bus.mem_we, 1'b0);
      resetn = 1'b1;

      do_req(1, 2'd2, 0, 32'h100, 32'hDEADBEEF, 0);
      do_req(0, 2'd2, 0, 32'h100, 32'h0, 0);
      do_req(1, 2'd2, 0, 32'h200, 32'h11223344, 0);
      do_req(1, 2'd0, 0, 32'h201, 32'h000000AA, 0);
      chk("byte_merge", mem[8'h80], 32'h1122AA44);
      do_req(1, 2'd2, 0, 32'h300, 32'h80FF0000, 0);
      do_req(0, 2'd0, 0, 32'h303, 32'h0, 0);
      do_req(0, 2'd0, 1, 32'h303, 32'h0, 0);
      do_req(0, 2'd1, 0, 32'h302, 32'h0, 0);
      do_req(1, 2'd2, 0, 32'h102, 32'h12345678, 0);
      do_req(0, 2'd1, 0, 32'h101, 32'h0, 0);
      do_req(0, 2'd3, 0, 32'h100, 32'h0, 1);
      do_req(0, 2'd2, 0, 32'h300, 32'h0, 3);

      // Reset asserted while a byte store sits in WRITE.
      bus.req_valid = 1; bus.req_we = 1; bus.req_size = 2'd0; bus.req_unsigned = 0;
      bus.req_addr = 32'h201; bus.req_wdata = 32'h55; bus.rsp_ready = 0;
      begin
         int w0;
         w0 = we_cnt;
         @(posedge clk); #1;
         bus.req_valid = 0;
         @(posedge clk); #1;
         chk("write_we", bus.mem_we, 1'b1);
         resetn = 1'b0;
         #1;
         chk("rst_gates_we", bus.mem_we, 1'b0);
         @(posedge clk); #1;
         chk("rstw_req_ready", bus.req_ready, 1'b1);
         chk("rstw_rsp_valid", bus.rsp_valid, 1'b0);
         chk("rstw_rdata", bus.rsp_rdata, 32'h0);
         chk("rstw_mis", bus.rsp_misaligned, 1'b0);
         chk("rstw_addr", bus.mem_address, 32'h0);
         chk("rstw_dout", bus.mem_data_out, 32'h0);
         chk("rstw_we_count", we_cnt - w0, 0);
         chk("rstw_word", mem[8'h80], 32'h1122AA44);
         resetn = 1'b1;
      end

      for (int t = 0; t < 300; t++) begin
         a = $urandom_range(0, 63);
         do_req(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom,
                int'($urandom_range(0, 2)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset; ports listed clock and reset first.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 resetn  input  1  synchronous active-low reset, sampled on rising edge of clk.
REQ-004 req_valid  input  1  core presents an access request.
REQ-005 req_ready  output  1  LSU accepts the request this cycle.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  access width: 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-008 req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-justified.
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  core consumes the response.
REQ-013 rsp_rdata  output  32  load result, extended; 0 for stores and faults.
REQ-014 rsp_misaligned  output  1  request faulted, no memory access made.
REQ-015 mem_address  output  32  word-aligned address to the word memory.
REQ-016 mem_data_out  output  32  write data to the memory data input.
REQ-017 mem_data_in  input  32  memory read data, combinational from mem_address.
REQ-018 mem_we  output  1  memory write enable, one word per asserted edge.

Function
REQ-019 FSM states: IDLE, ACCESS, WRITE, RESP; req_ready = 1 only in IDLE.
REQ-020 Request is accepted on a clock edge with req_valid = 1 and IDLE; all request fields are latched on that edge.
REQ-021 Misaligned: half with addr[0] = 1, word with addr[1:0] != 0, or size 11; IDLE -> RESP, rsp_misaligned = 1, rsp_rdata = 0, mem_we never asserted.
REQ-022 Aligned request: IDLE -> ACCESS.
REQ-023 mem_address = {latched addr[31:2], 2'b00} in ACCESS and WRITE; 0 otherwise.
REQ-024 Byte lanes are little-endian: byte k = addr[1:0] occupies bits [8k+7:8k]; a half at addr[1] = h occupies bits [16h+15:16h].
REQ-025 Load in ACCESS: extract the lane from mem_data_in, extend per req_unsigned, register it into rsp_rdata; ACCESS -> RESP.
REQ-026 Word store in ACCESS: mem_we = 1, mem_data_out = latched wdata; ACCESS -> RESP.
REQ-027 Byte/half store in ACCESS:
- register the merge of mem_data_in with wdata[7:0] or wdata[15:0] into the addressed lane, other lanes unchanged;
- mem_we = 0; ACCESS -> WRITE.
REQ-028 WRITE: mem_we = 1, mem_data_out = merged word; WRITE -> RESP.
REQ-029 mem_data_out = 0 whenever mem_we = 0.
REQ-030 RESP: rsp_valid = 1; stay in RESP while rsp_ready = 0, with rsp_rdata and rsp_misaligned held stable; RESP -> IDLE on rsp_ready = 1.
REQ-031 Latency from accept edge to first rsp_valid cycle:
- load and word store: 2 cycles;
- byte/half store: 3 cycles;
- misaligned: 1 cycle.
REQ-032 A new request is never accepted in the cycle rsp_valid is high; back-to-back throughput is one request per latency + 1 cycles.
REQ-033 At most one mem_we cycle per request; loads and faults never assert mem_we.

Reset
REQ-034 resetn = 0 at an edge forces IDLE and clears rsp_valid, rsp_rdata, rsp_misaligned and all latched request and merge registers.
REQ-035 mem_we SHALL be combinationally forced to 0 while resetn = 0, so reset in ACCESS or WRITE writes nothing.
REQ-036 After reset: req_ready = 1, mem_address = 0, mem_data_out = 0, mem_we = 0.

Verification
REQ-037 Word store 0xDEADBEEF @0x100, then word load @0x100 -> rsp_rdata = 0xDEADBEEF, rsp_valid 2 cycles after each accept.
REQ-038 Word 0x11223344 @0x200; byte store 0xAA @0x201 -> exactly one mem_we cycle (in WRITE); word becomes 0x1122AA44; rsp_valid 3 cycles after accept.
REQ-039 Word 0x80FF0000 @0x300:
- signed byte load @0x303 -> 0xFFFFFF80;
- unsigned byte load @0x303 -> 0x00000080;
- signed half load @0x302 -> 0xFFFF80FF.
REQ-040 Word store @0x102 and half load @0x101 -> rsp_misaligned = 1, rsp_rdata = 0, mem_we never high, memory unchanged.
REQ-041 Load with rsp_ready = 0 for 3 cycles -> rsp_valid and rsp_rdata held constant and req_ready = 0 throughout; IDLE on the edge after rsp_ready = 1.
REQ-042 resetn = 0 during WRITE of a byte store -> mem_we = 0 that cycle, target word unchanged, IDLE with all outputs at reset values next cycle.
